score_scan_display: RTL and testbench



---
 rtl/pong_disp_pkg.sv | 30 +++
 rtl/score_sync.sv | 51 +++++
 rtl/score_scan_display.sv | 111 +++++++++++
 tb/tb_score_scan_display.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pong_disp_pkg.sv
// Shared constants for the score display: segment patterns, digit slots and
// the decimal digit helpers used by the scan multiplexer.
package pong_disp_pkg;

  localparam int SCORE_W = 4;

  // Active-low patterns, bit order gfedcba
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_R1  = 2'd0;
  localparam logic [1:0] DIG_R10 = 2'd1;
  localparam logic [1:0] DIG_L1  = 2'd2;
  localparam logic [1:0] DIG_L10 = 2'd3;

  function automatic logic [6:0] seg_ones(input logic [SCORE_W-1:0] score);
    logic [SCORE_W-1:0] ones;
    ones = (score >= 4'd10) ? score - 4'd10 : score;
    return SEG_DIGIT[ones];
  endfunction

  // Scores top out at 15, so the tens digit is either blank or a 1
  function automatic logic [6:0] seg_tens(input logic [SCORE_W-1:0] score);
    return (score >= 4'd10) ? SEG_DIGIT[1] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/score_sync.sv
// Brings one score bus over from the game clock and accepts a value only once
// it has been seen on two consecutive synchronised samples.
module score_sync
  import pong_disp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] async_in,
  output logic [SCORE_W-1:0] value,
  output logic               changed
);

  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, hold_q, hold_d;
  logic [2:0]         fill_q, fill_d;
  logic               primed_q, primed_d;
  logic               stable;
  logic               settled;

  // The first settled value after reset is taken silently so reset never flashes
  always_comb begin
    s1_d     = async_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    stable   = (s2_q == s3_q);
    settled  = fill_q[2];
    value    = stable ? s3_q : hold_q;
    hold_d   = value;
    fill_d   = {fill_q[1:0], 1'b1};
    primed_d = primed_q | (stable & settled);
    changed  = stable & settled & primed_q & (s3_q != hold_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      hold_q   <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      hold_q   <= hold_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/score_scan_display.sv
// Four-digit multiplexed score display: left score on digits 3..2, right on
// 1..0, with a blink window on whichever side's score just changed.
module score_scan_display
  import pong_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int FLASH_TICKS = 512,
  parameter int BLINK_SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] Score_Left,
  input  logic [SCORE_W-1:0] Score_Right,
  output logic [6:0]         Seg,
  output logic [3:0]         An,
  output logic               Dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(FLASH_TICKS + 1);

  logic [SCORE_W-1:0] left_score, right_score;
  logic               left_changed, right_changed;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] flash_l_q, flash_l_d, flash_r_q, flash_r_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic          blank_l, blank_r;

  score_sync u_sync_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (Score_Left),
    .value    (left_score),
    .changed  (left_changed)
  );

  score_sync u_sync_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (Score_Right),
    .value    (right_score),
    .changed  (right_changed)
  );

  always_comb begin
    tick    = (presc_q == PW'(REFRESH_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    // A fresh change restarts the window even if a tick lands on the same cycle
    flash_l_d = flash_l_q;
    if (left_changed)
      flash_l_d = FW'(FLASH_TICKS);
    else if (tick && flash_l_q != '0)
      flash_l_d = flash_l_q - 1'b1;

    flash_r_d = flash_r_q;
    if (right_changed)
      flash_r_d = FW'(FLASH_TICKS);
    else if (tick && flash_r_q != '0)
      flash_r_d = flash_r_q - 1'b1;

    blank_l = (flash_l_q != '0) && !flash_l_q[BLINK_SHIFT];
    blank_r = (flash_r_q != '0) && !flash_r_q[BLINK_SHIFT];

    // Output registers load the slot being entered on each tick
    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (tick) begin
      an_d = ~(4'b0001 << idx_q);
      dp_d = (idx_q != DIG_L1);
      case (idx_q)
        DIG_L10: seg_d = blank_l ? SEG_BLANK : seg_tens(left_score);
        DIG_L1:  seg_d = blank_l ? SEG_BLANK : seg_ones(left_score);
        DIG_R10: seg_d = blank_r ? SEG_BLANK : seg_tens(right_score);
        default: seg_d = blank_r ? SEG_BLANK : seg_ones(right_score);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= DIG_R1;
      flash_l_q <= '0;
      flash_r_q <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      flash_l_q <= flash_l_d;
      flash_r_q <= flash_r_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign Seg = seg_q;
  assign An  = an_q;
  assign Dp  = dp_q;

endmodule

// File: tb/tb_score_scan_display.sv
// Drives directed and random score sequences into the display and compares
// every visible output against a reference model of the scan and blink rules.
module tb_score_scan_display;

  localparam int RD = 4;
  localparam int FT = 8;
  localparam int BS = 1;

  logic       clk;
  logic       rst_n;
  logic [3:0] Score_Left;
  logic [3:0] Score_Right;
  logic [6:0] Seg;
  logic [3:0] An;
  logic       Dp;

  int passCount  = 0;
  int checkCount = 0;
  bit checkEn    = 0;

  score_scan_display #(
    .REFRESH_DIV (RD),
    .FLASH_TICKS (FT),
    .BLINK_SHIFT (BS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Score_Left  (Score_Left),
    .Score_Right (Score_Right),
    .Seg         (Seg),
    .An          (An),
    .Dp          (Dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment pattern for a decimal digit, written out from the board's segment map
  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Reference model: per side, a history of sampled inputs (reset clears it to
  // zero), an accepted score, and the tick number at which its blink window began.
  logic [3:0] hist [2][3];
  logic [3:0] accHeld [2];
  bit         primed [2];
  bit         flashing [2];
  int         loadAt [2];
  int         cyc;
  int         nTicks;
  logic [3:0] expAn;
  logic [6:0] expSeg;
  logic       expDp;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] accNow [2];
    bit         chg [2];
    bit         stable;
    bit         tick;
    int         slot, side, score, f;
    bit         blank;
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 3; k++) hist[s][k] = 4'd0;
        accHeld[s]  = 4'd0;
        primed[s]   = 0;
        flashing[s] = 0;
        loadAt[s]   = 0;
      end
      cyc    = 0;
      nTicks = 0;
      expAn  = 4'b1111;
      expSeg = 7'b1111111;
      expDp  = 1'b1;
    end else begin
      tick = (cyc % RD) == (RD - 1);
      for (int s = 0; s < 2; s++) begin
        stable    = (hist[s][1] == hist[s][2]);
        accNow[s] = stable ? hist[s][2] : accHeld[s];
        chg[s]    = stable && (cyc >= 3) && primed[s] && (accNow[s] != accHeld[s]);
        if (stable && cyc >= 3) primed[s] = 1;
      end
      if (tick) begin
        slot  = nTicks % 4;
        side  = (slot >= 2) ? 0 : 1;
        score = accNow[side];
        f     = flashing[side] ? FT - (nTicks - loadAt[side]) : 0;
        if (f < 0) f = 0;
        blank = (f != 0) && (((f >> BS) & 1) == 0);
        expAn = ~(4'b0001 << slot);
        expDp = (slot != 2);
        if (slot == 3 || slot == 1)
          expSeg = (blank || score / 10 == 0) ? 7'b1111111 : segOf(score / 10);
        else
          expSeg = blank ? 7'b1111111 : segOf(score % 10);
        nTicks++;
      end
      for (int s = 0; s < 2; s++) begin
        if (chg[s]) begin
          loadAt[s]   = nTicks;
          flashing[s] = 1;
        end
        accHeld[s] = accNow[s];
        hist[s][2] = hist[s][1];
        hist[s][1] = hist[s][0];
      end
      hist[0][0] = Score_Left;
      hist[1][0] = Score_Right;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("An",  {3'b000, An}, {3'b000, expAn});
      checkOutput("Seg", Seg, expSeg);
      checkOutput("Dp",  {6'b0, Dp}, {6'b0, expDp});
    end
  end

  task automatic applyStimulus(input logic [3:0] l, input logic [3:0] r, input int holdCycles);
    Score_Left  = l;
    Score_Right = r;
    repeat (holdCycles) @(negedge clk);
  endtask

  task automatic checkBlank(input string tag);
    checkOutput({tag, "_An"},  {3'b000, An}, 7'b0001111);
    checkOutput({tag, "_Seg"}, Seg, 7'b1111111);
    checkOutput({tag, "_Dp"},  {6'b0, Dp}, 7'b0000001);
  endtask

  initial begin
    logic [3:0] l, r;
    rst_n       = 1'b0;
    Score_Left  = 4'd0;
    Score_Right = 4'd0;
    repeat (3) @(negedge clk);
    checkBlank("reset");
    rst_n   = 1'b1;
    checkEn = 1;

    applyStimulus(4'd0,  4'd0, 20);
    applyStimulus(4'd12, 4'd7, 40);
    applyStimulus(4'd12, 4'd8, 60);
    applyStimulus(4'd3,  4'd9, 60);
    applyStimulus(4'd5,  4'd9, 1);
    applyStimulus(4'd3,  4'd9, 40);
    applyStimulus(4'd15, 4'd9, 50);
    applyStimulus(4'd0,  4'd9, 50);

    applyStimulus(4'd10, 4'd9, 14);
    #1 rst_n = 1'b0;
    #1 checkBlank("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'd10, 4'd9, 60);

    l = 4'd10;
    r = 4'd9;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 6) l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6) r = 4'($urandom_range(0, 15));
      applyStimulus(l, r, $urandom_range(1, 24));
    end
    applyStimulus(l, r, 60);

    checkEn = 0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
